// File: rtl/fp_int_move_unit.sv
// Bit-pattern moves between the FP and integer register files (FMV.X.W/W.X/X.D/D.X)
// with sign-extension, NaN-boxing and a one-cycle, skid-buffered valid/ready pipeline.
module fp_int_move_unit #(
    parameter int XLEN  = 64,
    parameter int FLEN  = 64,
    parameter int TAG_W = 5,
    localparam int DW   = (XLEN > FLEN) ? XLEN : FLEN
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_int,
    input  logic [FLEN-1:0]  in_fp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_dest_fp,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int PW = DW + TAG_W + 2;
    localparam bit D_OK = (XLEN == 64) && (FLEN == 64);

    localparam logic [1:0] OP_X_W = 2'b00;
    localparam logic [1:0] OP_W_X = 2'b01;
    localparam logic [1:0] OP_X_D = 2'b10;

    logic [XLEN-1:0] sext_w;
    logic [FLEN-1:0] nanbox_w;
    logic [DW-1:0]   move_x_d;
    logic [DW-1:0]   move_d_x;

    // Width-dependent pieces live in generate branches so no zero-width replication is formed.
    generate
        if (XLEN == 64) begin : g_sext64
            assign sext_w = {{32{in_fp[31]}}, in_fp[31:0]};
        end else begin : g_sext32
            assign sext_w = in_fp[31:0];
        end
        if (FLEN == 64) begin : g_box64
            assign nanbox_w = {32'hFFFF_FFFF, in_int[31:0]};
        end else begin : g_box32
            assign nanbox_w = in_int[31:0];
        end
        if (D_OK) begin : g_dmove
            assign move_x_d = in_fp;
            assign move_d_x = in_int;
        end else begin : g_dnone
            assign move_x_d = '0;
            assign move_d_x = '0;
        end
    endgenerate

    logic [DW-1:0] in_data;
    logic          in_dest_fp;
    logic          in_illegal;
    logic [PW-1:0] in_pkt;

    always_comb begin
        in_data    = '0;
        in_dest_fp = 1'b0;
        in_illegal = 1'b0;
        case (in_op)
            OP_X_W: in_data[XLEN-1:0] = sext_w;
            OP_W_X: begin
                in_data[FLEN-1:0] = nanbox_w;
                in_dest_fp        = 1'b1;
            end
            OP_X_D: begin
                in_data    = move_x_d;
                in_illegal = !D_OK;
            end
            default: begin
                in_data    = move_d_x;
                in_dest_fp = 1'b1;
                in_illegal = !D_OK;
            end
        endcase
    end

    assign in_pkt = {in_illegal, in_dest_fp, in_tag, in_data};

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_pkt_q,   out_pkt_d;
    logic          skid_full_q, skid_full_d;
    logic [PW-1:0] skid_pkt_q,  skid_pkt_d;
    logic          in_ready_q,  in_ready_d;
    logic          in_xfer;
    logic          out_free;

    assign in_xfer  = in_valid && in_ready_q && EN;
    assign out_free = !out_valid_q || out_ready;

    // Skid contents always drain ahead of a fresh request so acceptance order is preserved.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pkt_d   = out_pkt_q;
        skid_full_d = skid_full_q;
        skid_pkt_d  = skid_pkt_q;
        if (EN) begin
            if (out_free) begin
                if (skid_full_q) begin
                    out_pkt_d   = skid_pkt_q;
                    out_valid_d = 1'b1;
                    skid_full_d = in_xfer;
                    if (in_xfer) begin
                        skid_pkt_d = in_pkt;
                    end
                end else if (in_xfer) begin
                    out_pkt_d   = in_pkt;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                skid_pkt_d  = in_pkt;
                skid_full_d = 1'b1;
            end
        end
        in_ready_d = EN && !skid_full_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            skid_full_q <= 1'b0;
            skid_pkt_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
            skid_full_q <= skid_full_d;
            skid_pkt_q  <= skid_pkt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_pkt_q[DW-1:0];
    assign out_tag     = out_pkt_q[DW +: TAG_W];
    assign out_dest_fp = out_pkt_q[DW + TAG_W];
    assign out_illegal = out_pkt_q[DW + TAG_W + 1];

endmodule

// File: doc/fp_int_move_unit.md
Name: fp_int_move_unit

Overview:
- Parametrised bit-pattern move unit between the FP and integer register files: FMV.X.W, FMV.W.X, FMV.X.D, FMV.D.X.
- Adds sign-extension and NaN-boxing.
- valid/ready handshake in and out, one-cycle latency, 2-entry skid buffer so the unit sustains one op per cycle under backpressure.
- Sits in the floating ALU beside the other FP ops; results go to integer or FP writeback, selected by out_dest_fp.

Parameters:
- XLEN, 64, integer register width; legal values 32 or 64.
- FLEN, 64, FP register width; legal values 32 or 64.
- TAG_W, 5, width of the destination-register tag carried with each op.
- DW is derived: max(XLEN,FLEN).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- EN  in  1  global enable; when low, no transfers occur and state is held.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  2  00 FMV_X_W, 01 FMV_W_X, 10 FMV_X_D, 11 FMV_D_X.
- in_int  in  XLEN  integer source operand.
- in_fp  in  FLEN  FP source operand.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DW  result; zero-extended to DW when the destination is narrower.
- out_dest_fp  out  1  1 = write FP file, 0 = write integer file.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  op not supported for the configured XLEN/FLEN; out_data = 0.

Behaviour:
- Reset (RST low, asynchronous): out_valid=0, out_data=0, out_dest_fp=0, out_tag=0, out_illegal=0, skid empty, in_ready=0.
- in_ready rises on the first CLK edge after RST deasserts, provided EN=1.
- Datapath, computed combinationally on the accepted request:
  - FMV_X_W: in_fp[31:0] sign-extended to XLEN (bit 31 replicated); dest_fp=0. No NaN-box check on the source.
  - FMV_W_X: in_int[31:0] NaN-boxed to FLEN (bits FLEN-1:32 all ones); dest_fp=1.
  - FMV_X_D: requires XLEN=64 and FLEN=64; result = in_fp[63:0]; dest_fp=0.
  - FMV_D_X: requires XLEN=64 and FLEN=64; result = in_int[63:0]; dest_fp=1.
  - D ops with XLEN or FLEN = 32: out_illegal=1, out_data=0, dest_fp as for the op. The result is still delivered through the handshake.
- Handshake:
  - Input transfer when in_valid && in_ready && EN.
  - Output transfer when out_valid && out_ready && EN.
  - Once raised, out_valid stays high and out_data, out_dest_fp, out_tag and out_illegal stay stable until the output transfer.
- Latency: a result accepted at edge N appears on the outputs after edge N, so out_valid=1 in cycle N+1 when the output stage was empty or draining.
- Storage: output register plus one skid register.
- in_ready is a registered signal: in_ready = !skid_full && EN.
- On each edge with EN=1:
  - Output empty or draining, input transfer: load output register from the input, or from skid if skid is full (skid has priority, preserving order). The new input then goes to skid.
  - Output held (out_valid && !out_ready), input transfer: input goes to skid; skid becomes full and in_ready drops next cycle.
  - Output draining, no input, skid full: skid moves to output; skid becomes empty.
  - Output draining, no input, skid empty: out_valid becomes 0.
- Simultaneous input and output transfer with skid empty: output register reloads; throughput is 1 op/cycle.
- EN low: no state change and no transfers; in_ready=0 from the next edge; out_valid and out_data hold.
- Ordering: results leave strictly in acceptance order; no drop, no duplicate.
- Reset mid-operation: all pending results are discarded; outputs return to their reset values immediately.

Test Plan:
- XLEN=FLEN=64, FMV_X_W, in_fp=0x0000_0000_C169_6042, tag=3 -> one cycle later out_data=0xFFFF_FFFF_C169_6042, out_dest_fp=0, out_tag=3.
- FMV_W_X, in_int=0x1234_5678_423D_0625 -> out_data=0xFFFF_FFFF_423D_0625, out_dest_fp=1. FMV_X_W with in_fp=0x...3F48_51EC sign bit 0 -> out_data=0x0000_0000_3F48_51EC.
- FMV_X_D in_fp=0xC029_2C08_3126_E979 -> out_data unchanged, out_dest_fp=0. Same op with FLEN=32 -> out_illegal=1, out_data=0.
- Backpressure: hold out_ready=0 and issue 3 back-to-back ops A,B,C -> A held on outputs, B in skid, in_ready=0, C not accepted. Raise out_ready -> A,B,C delivered in order on consecutive cycles.
- Streaming: out_ready=1, 16 consecutive ops -> 16 results on 16 consecutive cycles, in_ready constantly 1.
- Drop EN mid-stream -> outputs frozen, no transfers. Assert RST while out_valid=1 and skid full -> out_valid=0 immediately; first result after release is the first new request.
